exc_flush_ctrl: RTL and testbench

//  Exception/ERET commit controller behind the WB stage. Picks the highest-priority event on the

---
 rtl/exc_flush_ctrl_pkg.sv | 32 +++
 rtl/exc_prio_sel.sv | 39 +++
 rtl/exc_flush_ctrl.sv | 155 +++++++++++++++
 tb/tb_exc_flush_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_flush_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exc_flush_ctrl_pkg
// Description : Shared constants, FSM encodings and helpers for the
//               exception/ERET commit controller.
// Revision    : 1.0 - initial release
// ============================================================================
package exc_flush_ctrl_pkg;

    localparam logic [31:0] c_EXC_ENTRY_DEFAULT = 32'hbfc00380;

    localparam logic [4:0]  c_EXCCODE_INT  = 5'h00;
    localparam logic [4:0]  c_EXCCODE_ADEL = 5'h04;
    localparam logic [4:0]  c_EXCCODE_ADES = 5'h05;

    localparam logic [1:0]  c_ST_IDLE  = 2'd0;
    localparam logic [1:0]  c_ST_FLUSH = 2'd1;
    localparam logic [1:0]  c_ST_REDIR = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = c_ST_IDLE,
        ST_FLUSH = c_ST_FLUSH,
        ST_REDIR = c_ST_REDIR
    } state_e;

    // A delay-slot instruction restarts at its branch, one word earlier.
    function automatic logic [31:0] calc_epc(input logic [31:0] pc, input logic bd);
        return bd ? (pc - 32'd4) : pc;
    endfunction

endpackage : exc_flush_ctrl_pkg
`default_nettype wire

// File: rtl/exc_prio_sel.sv
`default_nettype none
// ============================================================================
// Module      : exc_prio_sel
// Description : Combinational pick of the highest-priority WB event
//               (interrupt > synchronous exception > ERET).
// Revision    : 1.0 - initial release
// ============================================================================
module exc_prio_sel
    import exc_flush_ctrl_pkg::*;
(
    input  logic       ws_valid,
    input  logic       ws_ex,
    input  logic [4:0] ws_excode,
    input  logic       ws_eret,
    input  logic       cp0_status_ie,
    input  logic       cp0_status_exl,
    input  logic [7:0] cp0_int_pend,
    output logic       take,
    output logic       is_int,
    output logic       is_eret,
    output logic [4:0] code
);

    logic w_int;
    logic w_ex;
    logic w_eret;

    always_comb begin
        w_int   = ws_valid & cp0_status_ie & ~cp0_status_exl & (|cp0_int_pend);
        w_ex    = ws_valid & ws_ex & ~w_int;
        w_eret  = ws_valid & ws_eret & ~w_int & ~ws_ex;
        take    = w_int | w_ex | w_eret;
        is_int  = w_int;
        is_eret = w_eret;
        code    = w_int ? c_EXCCODE_INT : ws_excode;
    end

endmodule : exc_prio_sel
`default_nettype wire

// File: rtl/exc_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : exc_flush_ctrl
// Description : Exception/ERET commit controller behind WB: kills the WB
//               write, pulses the CP0 update, flushes and redirects fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module exc_flush_ctrl
    import exc_flush_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_ENTRY  = c_EXC_ENTRY_DEFAULT,
    parameter int unsigned FLUSH_HOLD = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ws_valid,
    input  logic        ws_ex,
    input  logic [4:0]  ws_excode,
    input  logic        ws_bd,
    input  logic        ws_eret,
    input  logic [31:0] ws_pc,
    input  logic [31:0] ws_badvaddr,
    input  logic        cp0_status_ie,
    input  logic        cp0_status_exl,
    input  logic [7:0]  cp0_int_pend,
    input  logic [31:0] cp0_epc,
    input  logic        fs_redir_ready,
    output logic        ws_kill,
    output logic        exc_commit,
    output logic [4:0]  exc_code,
    output logic        exc_bd,
    output logic [31:0] exc_epc,
    output logic        badv_we,
    output logic [31:0] exc_badvaddr,
    output logic        eret_commit,
    output logic        flush_all,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam logic [2:0] c_CNT_LOAD = 3'(FLUSH_HOLD - 1);

    state_e      r_state;
    state_e      w_state_next;
    logic [2:0]  r_cnt;
    logic        r_exc_commit;
    logic        r_eret_commit;
    logic        r_badv_we;
    logic [4:0]  r_code;
    logic        r_bd;
    logic [31:0] r_epc;
    logic [31:0] r_badv;
    logic [31:0] r_redir_pc;

    logic        w_take;
    logic        w_is_int;
    logic        w_is_eret;
    logic        w_is_ex;
    logic [4:0]  w_code;
    logic        w_event;
    logic        w_is_adr;

    exc_prio_sel u_prio_sel (
        .ws_valid       (ws_valid),
        .ws_ex          (ws_ex),
        .ws_excode      (ws_excode),
        .ws_eret        (ws_eret),
        .cp0_status_ie  (cp0_status_ie),
        .cp0_status_exl (cp0_status_exl),
        .cp0_int_pend   (cp0_int_pend),
        .take           (w_take),
        .is_int         (w_is_int),
        .is_eret        (w_is_eret),
        .code           (w_code)
    );

    // Events are only honoured in IDLE; in FLUSH/REDIR the pipeline is empty.
    assign w_event  = w_take & (r_state == ST_IDLE);
    assign w_is_ex  = w_take & ~w_is_int & ~w_is_eret;
    assign w_is_adr = (ws_excode == c_EXCCODE_ADEL) | (ws_excode == c_EXCCODE_ADES);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        flush_all      = 1'b0;
        redirect_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_event) begin
                    w_state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                flush_all = 1'b1;
                if (r_cnt == 3'd0) begin
                    w_state_next = ST_REDIR;
                end
            end
            ST_REDIR: begin
                redirect_valid = 1'b1;
                if (fs_redir_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt         <= 3'd0;
            r_exc_commit  <= 1'b0;
            r_eret_commit <= 1'b0;
            r_badv_we     <= 1'b0;
            r_code        <= 5'h0;
            r_bd          <= 1'b0;
            r_epc         <= 32'h0;
            r_badv        <= 32'h0;
            r_redir_pc    <= 32'h0;
        end else begin
            r_exc_commit  <= w_event & ~w_is_eret;
            r_eret_commit <= w_event & w_is_eret;
            r_badv_we     <= w_event & w_is_ex & w_is_adr;
            if (w_event) begin
                r_cnt      <= c_CNT_LOAD;
                r_code     <= w_code;
                r_bd       <= ws_bd;
                r_epc      <= calc_epc(ws_pc, ws_bd);
                r_badv     <= ws_badvaddr;
                r_redir_pc <= w_is_eret ? cp0_epc : EXC_ENTRY;
            end else if ((r_state == ST_FLUSH) && (r_cnt != 3'd0)) begin
                r_cnt <= r_cnt - 3'd1;
            end
        end
    end

    assign ws_kill      = w_event;
    assign exc_commit   = r_exc_commit;
    assign eret_commit  = r_eret_commit;
    assign badv_we      = r_badv_we;
    assign exc_code     = r_code;
    assign exc_bd       = r_bd;
    assign exc_epc      = r_epc;
    assign exc_badvaddr = r_badv;
    assign redirect_pc  = r_redir_pc;

endmodule : exc_flush_ctrl
`default_nettype wire

// File: tb/tb_exc_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_exc_flush_ctrl
// Description : Self-checking bench: directed vector table, reset corners
//               and randomized events against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exc_flush_ctrl;

    localparam int          H     = 3;
    localparam logic [31:0] ENTRY = 32'hbfc00380;
    localparam int K_NONE = 0, K_INT = 1, K_EX = 2, K_ERET = 3;

    typedef struct {
        logic        valid, ex, bd, eret, ie, exl;
        logic [4:0]  excode;
        logic [31:0] pc, badv, cp0epc;
        logic [7:0]  pend;
    } stim_t;

    typedef struct {
        int          kind;
        logic [4:0]  code;
        logic        bd;
        logic [31:0] epc;
        logic        badv_we;
        logic [31:0] badv;
        logic [31:0] redir;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
        int    stall;
    } vec_t;

    logic        clk = 1'b0, reset = 1'b1;
    logic        ws_valid = 0, ws_ex = 0, ws_bd = 0, ws_eret = 0;
    logic [4:0]  ws_excode = '0;
    logic [31:0] ws_pc = '0, ws_badvaddr = '0, cp0_epc = '0;
    logic        cp0_status_ie = 0, cp0_status_exl = 0, fs_redir_ready = 0;
    logic [7:0]  cp0_int_pend = '0;
    logic        ws_kill, exc_commit, exc_bd, badv_we, eret_commit, flush_all, redirect_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_epc, exc_badvaddr, redirect_pc;

    int n_vec = 0;
    int n_err = 0;

    exc_flush_ctrl #(.EXC_ENTRY(ENTRY), .FLUSH_HOLD(H)) dut (
        .clk(clk), .reset(reset),
        .ws_valid(ws_valid), .ws_ex(ws_ex), .ws_excode(ws_excode), .ws_bd(ws_bd),
        .ws_eret(ws_eret), .ws_pc(ws_pc), .ws_badvaddr(ws_badvaddr),
        .cp0_status_ie(cp0_status_ie), .cp0_status_exl(cp0_status_exl),
        .cp0_int_pend(cp0_int_pend), .cp0_epc(cp0_epc), .fs_redir_ready(fs_redir_ready),
        .ws_kill(ws_kill), .exc_commit(exc_commit), .exc_code(exc_code), .exc_bd(exc_bd),
        .exc_epc(exc_epc), .badv_we(badv_we), .exc_badvaddr(exc_badvaddr),
        .eret_commit(eret_commit), .flush_all(flush_all),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level reference: what CP0/fetch must see for one WB instruction.
    function automatic exp_t model(input stim_t s);
        exp_t e;
        e.kind = K_NONE;
        if (s.valid) begin
            if (s.ie && !s.exl && s.pend != 8'h00) e.kind = K_INT;
            else if (s.ex)                         e.kind = K_EX;
            else if (s.eret)                       e.kind = K_ERET;
        end
        e.code    = (e.kind == K_INT) ? 5'h00 : s.excode;
        e.bd      = s.bd;
        e.epc     = s.bd ? s.pc - 32'd4 : s.pc;
        e.badv_we = (e.kind == K_EX) && (s.excode == 5'h04 || s.excode == 5'h05);
        e.badv    = s.badv;
        e.redir   = (e.kind == K_ERET) ? s.cp0epc : ENTRY;
        return e;
    endfunction

    function automatic stim_t mk(input logic valid, input logic ex, input logic [4:0] code,
                                 input logic bd, input logic eret, input logic [31:0] pc,
                                 input logic [31:0] badv, input logic ie, input logic exl,
                                 input logic [7:0] pend, input logic [31:0] cp0epc);
        stim_t s;
        s.valid = valid; s.ex = ex; s.excode = code; s.bd = bd; s.eret = eret;
        s.pc = pc; s.badv = badv; s.ie = ie; s.exl = exl; s.pend = pend; s.cp0epc = cp0epc;
        return s;
    endfunction

    function automatic exp_t mke(input int kind, input logic [4:0] code, input logic bd,
                                 input logic [31:0] epc, input logic bwe,
                                 input logic [31:0] badv, input logic [31:0] redir);
        exp_t e;
        e.kind = kind; e.code = code; e.bd = bd; e.epc = epc;
        e.badv_we = bwe; e.badv = badv; e.redir = redir;
        return e;
    endfunction

    task automatic drive(input stim_t s);
        ws_valid = s.valid; ws_ex = s.ex; ws_excode = s.excode; ws_bd = s.bd;
        ws_eret = s.eret; ws_pc = s.pc; ws_badvaddr = s.badv;
        cp0_status_ie = s.ie; cp0_status_exl = s.exl; cp0_int_pend = s.pend;
        cp0_epc = s.cp0epc;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".ws_kill"}, {31'd0, ws_kill}, 32'd0);
        chk({tag, ".exc_commit"}, {31'd0, exc_commit}, 32'd0);
        chk({tag, ".eret_commit"}, {31'd0, eret_commit}, 32'd0);
        chk({tag, ".badv_we"}, {31'd0, badv_we}, 32'd0);
        chk({tag, ".flush_all"}, {31'd0, flush_all}, 32'd0);
        chk({tag, ".redirect_valid"}, {31'd0, redirect_valid}, 32'd0);
        chk({tag, ".exc_code"}, {27'd0, exc_code}, 32'd0);
        chk({tag, ".exc_bd"}, {31'd0, exc_bd}, 32'd0);
        chk({tag, ".exc_epc"}, exc_epc, 32'd0);
        chk({tag, ".exc_badvaddr"}, exc_badvaddr, 32'd0);
        chk({tag, ".redirect_pc"}, redirect_pc, 32'd0);
    endtask

    // Starts in a post-edge window with the DUT idle; ends in the window where it is idle again.
    task automatic run_event(input stim_t s, input exp_t e, input int stall);
        fs_redir_ready = 1'b0;
        drive(s);
        #1;
        chk("ws_kill", {31'd0, ws_kill}, {31'd0, e.kind != K_NONE});
        step();
        ws_valid = 1'b0;
        ws_ex    = 1'b0;
        ws_eret  = 1'b0;
        if (e.kind == K_NONE) begin
            chk("idle.exc_commit", {31'd0, exc_commit}, 32'd0);
            chk("idle.eret_commit", {31'd0, eret_commit}, 32'd0);
            chk("idle.flush_all", {31'd0, flush_all}, 32'd0);
            return;
        end
        chk("exc_commit", {31'd0, exc_commit}, {31'd0, e.kind != K_ERET});
        chk("eret_commit", {31'd0, eret_commit}, {31'd0, e.kind == K_ERET});
        chk("badv_we", {31'd0, badv_we}, {31'd0, e.badv_we});
        chk("flush_all.t1", {31'd0, flush_all}, 32'd1);
        chk("redirect_valid.t1", {31'd0, redirect_valid}, 32'd0);
        if (e.kind != K_ERET) begin
            chk("exc_code", {27'd0, exc_code}, {27'd0, e.code});
            chk("exc_bd", {31'd0, exc_bd}, {31'd0, e.bd});
            chk("exc_epc", exc_epc, e.epc);
        end
        if (e.badv_we) chk("exc_badvaddr", exc_badvaddr, e.badv);
        for (int i = 2; i <= H; i++) begin
            step();
            chk("flush_all.hold", {31'd0, flush_all}, 32'd1);
            chk("pulses.once", {29'd0, exc_commit, eret_commit, badv_we}, 32'd0);
        end
        step();
        chk("redirect_valid", {31'd0, redirect_valid}, 32'd1);
        chk("redirect_pc", redirect_pc, e.redir);
        chk("flush_all.redir", {31'd0, flush_all}, 32'd0);
        for (int i = 1; i < stall; i++) begin
            step();
            chk("redirect_valid.stall", {31'd0, redirect_valid}, 32'd1);
            chk("redirect_pc.stall", redirect_pc, e.redir);
        end
        fs_redir_ready = 1'b1;
        step();
        fs_redir_ready = 1'b0;
        chk("redirect_valid.done", {31'd0, redirect_valid}, 32'd0);
    endtask

    vec_t tbl[10];

    initial begin
        tbl[0] = '{mk(1,1,5'h0c,0,0,32'hbfc00100,32'h0,0,0,8'h00,32'h0),
                   mke(K_EX,5'h0c,0,32'hbfc00100,0,32'h0,ENTRY), 0};
        tbl[1] = '{mk(1,1,5'h04,1,0,32'h80001008,32'h00000003,0,0,8'h00,32'h0),
                   mke(K_EX,5'h04,1,32'h80001004,1,32'h00000003,ENTRY), 2};
        tbl[2] = '{mk(1,0,5'h00,0,1,32'h80000300,32'h0,0,1,8'h00,32'h80002000),
                   mke(K_ERET,5'h00,0,32'h80000300,0,32'h0,32'h80002000), 0};
        tbl[3] = '{mk(1,1,5'h0a,0,0,32'h80000040,32'h0,1,0,8'h80,32'h0),
                   mke(K_INT,5'h00,0,32'h80000040,0,32'h0,ENTRY), 1};
        tbl[4] = '{mk(1,1,5'h0a,0,0,32'h80000040,32'h0,1,1,8'h80,32'h0),
                   mke(K_EX,5'h0a,0,32'h80000040,0,32'h0,ENTRY), 0};
        tbl[5] = '{mk(1,1,5'h08,0,0,32'h80000200,32'h0,0,0,8'h00,32'h0),
                   mke(K_EX,5'h08,0,32'h80000200,0,32'h0,ENTRY), 5};
        tbl[6] = '{mk(1,0,5'h00,1,1,32'h80000400,32'h0,0,1,8'h00,32'h9fc01234),
                   mke(K_ERET,5'h00,1,32'h800003fc,0,32'h0,32'h9fc01234), 0};
        tbl[7] = '{mk(1,1,5'h05,1,0,32'h00000000,32'h12345678,0,0,8'h00,32'h0),
                   mke(K_EX,5'h05,1,32'hfffffffc,1,32'h12345678,ENTRY), 0};
        tbl[8] = '{mk(0,1,5'h04,0,0,32'h80000000,32'h0,1,0,8'h01,32'h0),
                   mke(K_NONE,5'h04,0,32'h80000000,0,32'h0,ENTRY), 0};
        tbl[9] = '{mk(1,0,5'h00,0,0,32'h80000010,32'h0,1,0,8'h04,32'h0),
                   mke(K_INT,5'h00,0,32'h80000010,0,32'h0,ENTRY), 3};

        reset = 1'b1;
        step();
        step();
        check_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < 10; i++) run_event(tbl[i].s, tbl[i].e, tbl[i].stall);

        // Reset landing mid-FLUSH.
        drive(tbl[0].s);
        step();
        ws_valid = 1'b0;
        reset = 1'b1;
        step();
        check_zero("rst_flush");
        reset = 1'b0;
        run_event(tbl[1].s, tbl[1].e, 0);

        // Reset landing mid-REDIR while fetch is stalled.
        fs_redir_ready = 1'b0;
        drive(tbl[2].s);
        step();
        ws_valid = 1'b0;
        for (int i = 1; i <= H; i++) step();
        chk("pre_rst.redirect_valid", {31'd0, redirect_valid}, 32'd1);
        reset = 1'b1;
        step();
        check_zero("rst_redir");
        reset = 1'b0;
        run_event(tbl[3].s, tbl[3].e, 0);

        for (int n = 0; n < 150; n++) begin
            stim_t s;
            s.valid  = ($urandom_range(0, 9) != 0);
            s.ex     = 1'($urandom);
            s.excode = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(4, 5)) : 5'($urandom);
            s.bd     = 1'($urandom);
            s.eret   = 1'($urandom);
            s.pc     = $urandom;
            s.badv   = $urandom;
            s.ie     = 1'($urandom);
            s.exl    = 1'($urandom);
            s.pend   = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            s.cp0epc = $urandom;
            run_event(s, model(s), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_exc_flush_ctrl
`default_nettype wire
